sdsg_mc: RTL
============

# sdsg_mc

Multi-channel selectable delay signal generator. It is the parametrised successor of the single-bit tapped shift-register delay and is used in the timing/stimulus path wherever one sample stream needs several independently delayed copies. It stores the last DEPTH accepted samples of a WIDTH-bit stream in a circular buffer. TAPS output taps each read that history at their own delay, and each tap reports per-tap validity once its delay window has filled.

## Interface
- WIDTH, 8: sample width in bits, ≥1.
- DEPTH, 256: history length in samples. Must be a power of two, ≥2.
- TAPS, 2: number of independent output taps, ≥1.
- RESET_VAL, 0: WIDTH-bit value driven on any tap that is not valid.
- AW = $clog2(DEPTH) and TW = max(1,$clog2(TAPS)) are derived localparams.

Ports (clock and reset first):
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- en_i  in  1  accept data_i as a new sample on this edge.
- data_i  in  WIDTH  input sample.
- flush_i  in  1  synchronous clear of history and all fill counters.
- cfg_we_i  in  1  write cfg_delay_i into the delay register of tap cfg_tap_i.
- cfg_tap_i  in  TW  tap index. Writes with an index ≥ TAPS are ignored.
- cfg_delay_i  in  AW  new delay for the selected tap (0..DEPTH-1).
- data_o  out  TAPS*WIDTH  tap t occupies bits [t*WIDTH +: WIDTH].
- valid_o  out  TAPS  bit t is high when tap t is valid.

## Operation
- Sample count: s[k] is the k-th accepted sample. A sample is accepted on a rising edge with en_i=1 and flush_i=0.
- Write side: s[k] is written to mem[wptr], and wptr then increments modulo DEPTH, wrapping naturally at AW bits.
- Tap read: tap t with delay d reads mem[(wptr-1-d) mod DEPTH]. Delay 0 is therefore the most recently accepted sample, which matches the predecessor's delay_num=0 behaviour.
- Fill counters: each tap has fill_t, which increments on each accepted sample and saturates at DEPTH.
  - valid_o[t] = (fill_t ≥ d_t+1).
  - data_o for tap t = mem read when valid_o[t]=1, otherwise RESET_VAL.
- Delay change: a write with cfg_we_i=1 sets d_t and clears fill_t to 0.
  - If a sample is accepted on the same edge, that sample is not counted: fill_t = 0 after the edge.
  - Only the addressed tap is affected. All other taps continue unchanged.
- Flush: flush_i=1 sets wptr=0 and clears every fill_t.
  - en_i is ignored that cycle. A simultaneous cfg write still updates d_t.
  - Memory contents are not cleared. Masking by valid_o hides stale data.
- Reset (asynchronous, any time, including mid-stream):
  - wptr=0, all fill_t=0, all d_t=0.
  - valid_o=0 and every data_o tap = RESET_VAL immediately, without waiting for a clock.
  - The memory is not reset.
- Priority on the same edge: reset > flush > (sample accept, cfg write).

## Timing
- Base build: data_o and valid_o are combinational from registered state and change only after clock edges or reset.
- With continuous en_i=1 and delay d: an input presented at edge n appears on the tap output after edge n+d, i.e. d+1 cycles of latency.
- en_i=0 freezes all outputs. Delays are counted in accepted samples, not cycles.
- First valid output after reset, flush or delay change: the edge on which the (d+1)-th subsequent sample is accepted.
- Wrap-around: wptr rolls over from DEPTH-1 to 0 with no gap. d=DEPTH-1 reads the oldest retained sample.

## Configuration
- SDSG_MC_OUTREG_EN defined: data_o and valid_o are registered.
  - Every observable response is one clock later than in the base build, including after flush and cfg writes.
  - The output registers reset asynchronously to RESET_VAL and 0.
- Not defined: the combinational output path described above.

## Test plan
- Reset, then DEPTH=256, WIDTH=8, tap0 d=0, tap1 d=3, en_i=1, data_i=0x01,0x02,0x03…
  - tap0 shows 0x01 after edge 1, valid from edge 1.
  - tap1 is valid from edge 4 showing 0x01, then tracks input delayed 4 cycles.
- Stream 300 samples with tap0 d=255.
  - valid rises on the 256th sample.
  - After sample 300, tap0 shows sample 45, proving correct wrap.
- Mid-stream write tap1 d=1 with en_i=1 on the same edge.
  - valid_o[1] drops, is still 0 after the next sample, and rises after the second following sample.
  - Tap0 is undisturbed.
- Toggle en_i 1,0,0,1 with tap0 d=2: outputs hold during the idle cycles, and the delay counts samples, not cycles.
- Assert flush_i with en_i=1: all valid_o=0 and data_o=RESET_VAL afterward, and the flush-cycle sample is not stored.
- Assert rst_n_i low between clock edges mid-stream: outputs go to RESET_VAL and 0 before the next edge, and all delays return to 0. Repeat the first scenario with SDSG_MC_OUTREG_EN defined and check every response is shifted by one cycle.

Source files
------------

// File: rtl/sdsg_mc_if.sv
// sdsg_mc_if: sample/config/tap bundle for the multi-channel delay generator.
// The master side (stimulus source) drives the sample stream and the tap
// configuration; the slave side (sdsg_mc) returns the per-tap data and valids.
interface sdsg_mc_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int TAPS  = 2
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic                    en_i;
    logic [WIDTH-1:0]        data_i;
    logic                    flush_i;
    logic                    cfg_we_i;
    logic [TW-1:0]           cfg_tap_i;
    logic [AW-1:0]           cfg_delay_i;
    logic [TAPS*WIDTH-1:0]   data_o;
    logic [TAPS-1:0]         valid_o;

    modport master (
        output en_i, data_i, flush_i, cfg_we_i, cfg_tap_i, cfg_delay_i,
        input  data_o, valid_o
    );

    modport slave (
        input  en_i, data_i, flush_i, cfg_we_i, cfg_tap_i, cfg_delay_i,
        output data_o, valid_o
    );
endinterface

// File: rtl/sdsg_mc.sv
// sdsg_mc: multi-channel selectable delay signal generator.
// Keeps the last DEPTH accepted samples in a circular buffer; each of TAPS
// taps reads that history at its own programmable delay (in accepted samples)
// and flags valid once enough samples have arrived since the last reset,
// flush or delay change.
// Optional build macro: SDSG_MC_OUTREG_EN registers data_o/valid_o, adding
// one clock of latency to every observable response.
module sdsg_mc #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 256,
    parameter int               TAPS      = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    sdsg_mc_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
    // Fill counters need one extra bit so they can hold DEPTH itself.
    localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH);

    // History buffer: deliberately not reset, stale entries are masked by fill.
    logic [WIDTH-1:0]      mem_q [DEPTH];

    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW:0]           fill_q  [TAPS];
    logic [AW:0]           fill_d  [TAPS];
    logic [AW-1:0]         delay_q [TAPS];
    logic [AW-1:0]         delay_d [TAPS];

    logic                  accept;
    logic [TAPS-1:0]       cfg_hit;
    logic [AW-1:0]         rd_addr [TAPS];
    logic [TAPS*WIDTH-1:0] data_c;
    logic [TAPS-1:0]       valid_c;

    // Flush wins over a sample on the same edge; the flush-cycle sample is dropped.
    assign accept = bus.en_i & ~bus.flush_i;

    // Decode which tap (if any) the configuration write addresses; indices
    // beyond the last tap never match.
    always_comb begin
        cfg_hit = '0;
        for (int t = 0; t < TAPS; t++) begin
            cfg_hit[t] = bus.cfg_we_i && (bus.cfg_tap_i == TW'(t));
        end
    end

    // Next-state for write pointer, delays and fill counters.
    always_comb begin
        wptr_d = wptr_q;
        if (bus.flush_i) begin
            wptr_d = '0;
        end else if (accept) begin
            wptr_d = wptr_q + AW'(1);
        end

        for (int t = 0; t < TAPS; t++) begin
            delay_d[t] = delay_q[t];
            fill_d[t]  = fill_q[t];
            // A delay write still lands during a flush.
            if (cfg_hit[t]) begin
                delay_d[t] = bus.cfg_delay_i;
            end
            // A delay write restarts the window; a same-edge sample is not counted.
            if (bus.flush_i || cfg_hit[t]) begin
                fill_d[t] = '0;
            end else if (accept && (fill_q[t] != FILL_MAX)) begin
                fill_d[t] = fill_q[t] + (AW+1)'(1);
            end
        end
    end

    // Control state with asynchronous clear; delays return to 0 on reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            for (int t = 0; t < TAPS; t++) begin
                fill_q[t]  <= '0;
                delay_q[t] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            for (int t = 0; t < TAPS; t++) begin
                fill_q[t]  <= fill_d[t];
                delay_q[t] <= delay_d[t];
            end
        end
    end

    // Sample storage at the current write pointer.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem_q[wptr_q] <= bus.data_i;
        end
    end

    // Tap read: delay 0 is the most recent sample (one behind the write pointer);
    // the address wraps naturally in AW bits. Valid means fill >= delay+1.
    always_comb begin
        data_c  = '0;
        valid_c = '0;
        for (int t = 0; t < TAPS; t++) begin
            rd_addr[t] = wptr_q - AW'(1) - delay_q[t];
            valid_c[t] = fill_q[t] > {1'b0, delay_q[t]};
            data_c[t*WIDTH +: WIDTH] = valid_c[t] ? mem_q[rd_addr[t]] : RESET_VAL;
        end
    end

`ifdef SDSG_MC_OUTREG_EN
    logic [TAPS*WIDTH-1:0] data_q;
    logic [TAPS-1:0]       valid_q;

    // Registered outputs: one extra clock on every response, async cleared.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q  <= {TAPS{RESET_VAL}};
            valid_q <= '0;
        end else begin
            data_q  <= data_c;
            valid_q <= valid_c;
        end
    end

    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
`else
    assign bus.data_o  = data_c;
    assign bus.valid_o = valid_c;
`endif

endmodule
